// File: rtl/friscv_perf_counters.sv
`default_nettype none
// ============================================================================
// Module   : friscv_perf_counters
// Purpose  : Bank of NB_EVT+1 performance counters. Counter 0 counts enabled
//            cycles, counter k (k>0) counts enabled evt[k-1] pulses. Counters
//            are read over a valid/ready request/response port as XLEN-wide
//            halves. A low-half read snapshots the counter so that a
//            following high-half read of the same index is coherent.
// Ports    : aclk_i / aresetn_i / srst_i  clock, async reset, sync reset
//            enable_i, evt_i, clr_i        counting controls
//            req_valid_i/req_ready_o/req_addr_i   read request {idx, half}
//            rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o  read response
//            ovf_o                         sticky per-counter overflow flags
// Revision : 1.0 - initial release
// ============================================================================
module friscv_perf_counters #(
    parameter  int XLEN   = 32,
    parameter  int NB_EVT = 4,
    parameter  int CNT_W  = 64,
    localparam int NB_CNT = NB_EVT + 1,
    localparam int IDX_W  = $clog2(NB_CNT),
    localparam int ADDR_W = IDX_W + 1
) (
    input  logic              aclk_i,
    input  logic              aresetn_i,
    input  logic              srst_i,
    input  logic              enable_i,
    input  logic [NB_EVT-1:0] evt_i,
    input  logic [NB_CNT-1:0] clr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_data_o,
    output logic              rsp_err_o,
    output logic [NB_CNT-1:0] ovf_o
);

    // ------------------------------------------------------------------
    // Counter bank
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  w_cnt [NB_CNT];
    logic [NB_CNT-1:0] w_ovf;

    for (genvar gi = 0; gi < NB_CNT; gi++) begin : g_cnt
        logic             w_inc;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             ovf_q, ovf_d;

        if (gi == 0) begin : g_cycle
            assign w_inc = enable_i;
        end else begin : g_event
            assign w_inc = enable_i & evt_i[gi-1];
        end

        // Clear takes priority over an increment in the same cycle, so a
        // clear coinciding with a wrap leaves both counter and flag at zero.
        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (srst_i || clr_i[gi]) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (w_inc) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                end
            end
        end

        always_ff @(posedge aclk_i or negedge aresetn_i) begin
            if (!aresetn_i) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        assign w_cnt[gi] = cnt_q;
        assign w_ovf[gi] = ovf_q;
    end

    assign ovf_o = w_ovf;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_idx;
    logic             w_half;
    logic             w_in_range;
    logic             w_accept;
    logic [CNT_W-1:0] w_sel;

    assign w_idx       = req_addr_i[ADDR_W-1:1];
    assign w_half      = req_addr_i[0];
    assign w_in_range  = (int'(w_idx) < NB_CNT);
    assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
    assign w_accept    = req_valid_i & req_ready_o;

    // Out-of-range indices select zero rather than an undefined entry.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NB_CNT; i++) begin
            if (int'(w_idx) == i) begin
                w_sel = w_cnt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot: tag tracks which counter the last low read captured.
    // Only the upper part is ever served from the snapshot, so only that
    // part is stored; the low half is always returned live.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] snap_tag_q, snap_tag_d;
    logic             snap_vld_q, snap_vld_d;
    logic [XLEN-1:0]  w_hi_live;
    logic [XLEN-1:0]  w_hi_snap;
    logic             w_snap_hit;

    assign w_snap_hit = snap_vld_q && (snap_tag_q == w_idx);

    always_comb begin
        snap_tag_d = snap_tag_q;
        snap_vld_d = snap_vld_q;
        if (srst_i) begin
            snap_tag_d = '0;
            snap_vld_d = 1'b0;
        end else if (w_accept && w_in_range) begin
            if (!w_half) begin
                snap_tag_d = w_idx;
                snap_vld_d = 1'b1;
            end else begin
                snap_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            snap_tag_q <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            snap_tag_q <= snap_tag_d;
            snap_vld_q <= snap_vld_d;
        end
    end

    if (CNT_W > XLEN) begin : g_hi
        localparam int HI_W = CNT_W - XLEN;
        logic [HI_W-1:0] snap_hi_q, snap_hi_d;

        always_comb begin
            snap_hi_d = snap_hi_q;
            if (srst_i) begin
                snap_hi_d = '0;
            end else if (w_accept && w_in_range && !w_half) begin
                snap_hi_d = w_sel[CNT_W-1:XLEN];
            end
        end

        always_ff @(posedge aclk_i or negedge aresetn_i) begin
            if (!aresetn_i) begin
                snap_hi_q <= '0;
            end else begin
                snap_hi_q <= snap_hi_d;
            end
        end

        assign w_hi_live = XLEN'(w_sel[CNT_W-1:XLEN]);
        assign w_hi_snap = XLEN'(snap_hi_q);
    end else begin : g_no_hi
        // The counter fits in the low half, so the high half is always zero.
        assign w_hi_live = '0;
        assign w_hi_snap = '0;
    end

    // ------------------------------------------------------------------
    // Single-entry response buffer
    // ------------------------------------------------------------------
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] w_rd_data;

    always_comb begin
        w_rd_data = '0;
        if (w_in_range) begin
            if (w_half) begin
                w_rd_data = w_snap_hit ? w_hi_snap : w_hi_live;
            end else begin
                w_rd_data = XLEN'(w_sel);
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (srst_i) begin
            rsp_valid_d = 1'b0;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b0;
        end else if (w_accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = w_rd_data;
            rsp_err_d   = ~w_in_range;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_friscv_perf_counters.sv
`default_nettype none
// ============================================================================
// Module   : tb_friscv_perf_counters
// Purpose  : Directed self-checking bench. Three instances share one set of
//            stimulus: A (XLEN=32, CNT_W=64), B (XLEN=8, CNT_W=16, used for
//            the snapshot/coherency scenario at a reachable count) and
//            C (XLEN=32, CNT_W=8, used for wrap and overflow).
// Revision : 1.0 - initial release
// ============================================================================
module tb_friscv_perf_counters;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       srst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] evt = '0;
    logic [4:0] clr = '0;
    logic       req_valid = 1'b0;
    logic [3:0] req_addr = '0;
    logic       rsp_ready = 1'b1;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_data_a;
    logic [4:0]  ovf_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [7:0]  rsp_data_b;
    logic [4:0]  ovf_b;
    logic        req_ready_c, rsp_valid_c, rsp_err_c;
    logic [31:0] rsp_data_c;
    logic [4:0]  ovf_c;

    int checks = 0;
    int errors = 0;

    // Results of the last rd() call
    logic        got_vld, got_err, got_err_c;
    logic [31:0] got_a, got_c;
    logic [7:0]  got_b;

    // Handshake monitor for instance A
    int n_acc = 0;
    int n_rsp = 0;

    always #5 aclk = ~aclk;

    friscv_perf_counters #(.XLEN(32), .NB_EVT(4), .CNT_W(64)) u_dut_a (
        .aclk_i(aclk), .aresetn_i(aresetn), .srst_i(srst), .enable_i(enable),
        .evt_i(evt), .clr_i(clr), .req_valid_i(req_valid), .req_ready_o(req_ready_a),
        .req_addr_i(req_addr), .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data_a), .rsp_err_o(rsp_err_a), .ovf_o(ovf_a)
    );

    friscv_perf_counters #(.XLEN(8), .NB_EVT(4), .CNT_W(16)) u_dut_b (
        .aclk_i(aclk), .aresetn_i(aresetn), .srst_i(srst), .enable_i(enable),
        .evt_i(evt), .clr_i(clr), .req_valid_i(req_valid), .req_ready_o(req_ready_b),
        .req_addr_i(req_addr), .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data_b), .rsp_err_o(rsp_err_b), .ovf_o(ovf_b)
    );

    friscv_perf_counters #(.XLEN(32), .NB_EVT(4), .CNT_W(8)) u_dut_c (
        .aclk_i(aclk), .aresetn_i(aresetn), .srst_i(srst), .enable_i(enable),
        .evt_i(evt), .clr_i(clr), .req_valid_i(req_valid), .req_ready_o(req_ready_c),
        .req_addr_i(req_addr), .rsp_valid_o(rsp_valid_c), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data_c), .rsp_err_o(rsp_err_c), .ovf_o(ovf_c)
    );

    always @(posedge aclk) begin
        if (req_valid && req_ready_a) n_acc <= n_acc + 1;
        if (rsp_valid_a && rsp_ready)  n_rsp <= n_rsp + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // All stimulus changes happen on the falling edge; outputs are sampled there.
    task automatic do_reset();
        enable = 1'b0; evt = '0; clr = '0; srst = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        @(negedge aclk); aresetn = 1'b0;
        @(negedge aclk);
        @(negedge aclk); aresetn = 1'b1;
    endtask

    // One-cycle request, response sampled one cycle after acceptance.
    task automatic rd(input logic [3:0] addr);
        @(negedge aclk);
        req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        got_vld = rsp_valid_a; got_err = rsp_err_a; got_a = rsp_data_a;
        got_b = rsp_data_b; got_c = rsp_data_c; got_err_c = rsp_err_c;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_a); end
        checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready_a); end
        checks++; if ({ovf_a, ovf_b, ovf_c} !== 15'd0) begin errors++; $display("FAIL reset_ovf: got %h expected 0", {ovf_a, ovf_b, ovf_c}); end
        checks++; if ({rsp_data_a, rsp_err_a} !== 33'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", {rsp_data_a, rsp_err_a}); end
    endtask

    task automatic test_cycle_count();
        do_reset();
        enable = 1'b1;
        repeat (10) @(negedge aclk);
        enable = 1'b0;
        rd(4'b0000);
        checks++; if (got_vld !== 1'b1) begin errors++; $display("FAIL t1_latency: rsp_valid %b expected 1", got_vld); end
        checks++; if (got_a !== 32'd10) begin errors++; $display("FAIL t1_cnt0: got %0d expected 10", got_a); end
        checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL t1_err: got %b expected 0", got_err); end
        @(negedge aclk);
        checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL t1_rsp_drop: rsp_valid %b expected 0", rsp_valid_a); end
    endtask

    task automatic test_event_freeze();
        do_reset();
        evt = 4'b0001; enable = 1'b1;
        repeat (2) @(negedge aclk);
        enable = 1'b0;
        repeat (2) @(negedge aclk);
        enable = 1'b1;
        repeat (1) @(negedge aclk);
        evt = '0; enable = 1'b0;
        rd(4'b0010);
        checks++; if (got_a !== 32'd3) begin errors++; $display("FAIL t2_cnt1: got %0d expected 3", got_a); end
        rd(4'b0000);
        checks++; if (got_a !== 32'd3) begin errors++; $display("FAIL t2_cnt0: got %0d expected 3", got_a); end
        rd(4'b0001);
        checks++; if (got_a !== 32'd0 || got_err !== 1'b0) begin errors++; $display("FAIL t2_cnt0_high: got %h err %b expected 0 err 0", got_a, got_err); end
    endtask

    task automatic test_snapshot();
        do_reset();
        evt = 4'b0010; enable = 1'b1;
        repeat (255) @(negedge aclk);
        evt = '0; enable = 1'b0;
        rd(4'b0100);
        checks++; if (got_b !== 8'hFF) begin errors++; $display("FAIL t3_low: got %h expected ff", got_b); end
        evt = 4'b0010; enable = 1'b1;
        @(negedge aclk);
        evt = '0; enable = 1'b0;
        rd(4'b0101);
        checks++; if (got_b !== 8'h00) begin errors++; $display("FAIL t3_high_snap: got %h expected 00", got_b); end
        rd(4'b0101);
        checks++; if (got_b !== 8'h01) begin errors++; $display("FAIL t3_high_live: got %h expected 01", got_b); end
        // Low read of counter 2, then of counter 1, overwrites the snapshot.
        rd(4'b0100);
        checks++; if (got_b !== 8'h00) begin errors++; $display("FAIL t3_low2: got %h expected 00", got_b); end
        rd(4'b0010);
        evt = 4'b0010; enable = 1'b1;
        repeat (256) @(negedge aclk);
        evt = '0; enable = 1'b0;
        rd(4'b0101);
        checks++; if (got_b !== 8'h02) begin errors++; $display("FAIL t3_interleave: got %h expected 02", got_b); end
    endtask

    task automatic test_wrap_clear();
        do_reset();
        evt = 4'b0100; enable = 1'b1;
        repeat (255) @(negedge aclk);
        evt = '0; enable = 1'b0;
        checks++; if (ovf_c !== 5'b00000) begin errors++; $display("FAIL t4_pre_wrap_ovf: got %b expected 00000", ovf_c); end
        evt = 4'b0100; enable = 1'b1;
        @(negedge aclk);
        evt = '0; enable = 1'b0;
        checks++; if (ovf_c !== 5'b01001) begin errors++; $display("FAIL t4_wrap_ovf: got %b expected 01001", ovf_c); end
        rd(4'b0110);
        checks++; if (got_c !== 32'd0 || got_err_c !== 1'b0) begin errors++; $display("FAIL t4_wrap_cnt: got %0d err %b expected 0 err 0", got_c, got_err_c); end
        rd(4'b0111);
        checks++; if (got_c !== 32'd0) begin errors++; $display("FAIL t4_high_zero: got %h expected 0", got_c); end
        evt = 4'b0100; enable = 1'b1;
        repeat (255) @(negedge aclk);
        clr = 5'b01000;
        @(negedge aclk);
        clr = '0; evt = '0; enable = 1'b0;
        checks++; if (ovf_c !== 5'b00001) begin errors++; $display("FAIL t4_clr_ovf: got %b expected 00001", ovf_c); end
        rd(4'b0110);
        checks++; if (got_c !== 32'd0) begin errors++; $display("FAIL t4_clr_cnt: got %0d expected 0", got_c); end
    endtask

    task automatic test_back_to_back();
        int acc0;
        int rsp0;
        do_reset();
        evt = 4'b0001; enable = 1'b1;
        repeat (3) @(negedge aclk);
        evt = '0;
        repeat (4) @(negedge aclk);
        enable = 1'b0;
        acc0 = n_acc; rsp0 = n_rsp;
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'b0000;
        @(negedge aclk);
        req_addr = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready_a !== 1'b0 || rsp_valid_a !== 1'b1 || rsp_data_a !== 32'd7) begin
                errors++;
                $display("FAIL t5_stall%0d: ready %b valid %b data %0d expected 0 1 7", i, req_ready_a, rsp_valid_a, rsp_data_a);
            end
            @(negedge aclk);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        checks++; if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'd3) begin errors++; $display("FAIL t5_second: valid %b data %0d expected 1 3", rsp_valid_a, rsp_data_a); end
        @(negedge aclk);
        checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL t5_drain: valid %b expected 0", rsp_valid_a); end
        checks++; if ((n_acc - acc0) != 2 || (n_rsp - rsp0) != 2) begin errors++; $display("FAIL t5_counts: acc %0d rsp %0d expected 2 2", n_acc - acc0, n_rsp - rsp0); end
    endtask

    task automatic test_srst();
        do_reset();
        enable = 1'b1;
        repeat (5) @(negedge aclk);
        srst = 1'b1;
        @(negedge aclk);
        srst = 1'b0; enable = 1'b0;
        rd(4'b0000);
        checks++; if (got_a !== 32'd0) begin errors++; $display("FAIL srst_cnt0: got %0d expected 0", got_a); end
    endtask

    task automatic test_err_reset();
        do_reset();
        rd(4'b1110);
        checks++; if (got_vld !== 1'b1 || got_err !== 1'b1 || got_a !== 32'd0) begin errors++; $display("FAIL t6_idx7: valid %b err %b data %h expected 1 1 0", got_vld, got_err, got_a); end
        rd(4'b1010);
        checks++; if (got_err !== 1'b1 || got_a !== 32'd0) begin errors++; $display("FAIL t6_idx5: err %b data %h expected 1 0", got_err, got_a); end
        rd(4'b1000);
        checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL t6_idx4: err %b expected 0", got_err); end
        enable = 1'b1;
        repeat (256) @(negedge aclk);
        enable = 1'b0;
        checks++; if (ovf_c !== 5'b00001) begin errors++; $display("FAIL t6_pre_ovf: got %b expected 00001", ovf_c); end
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'b0000;
        @(negedge aclk);
        req_valid = 1'b0;
        checks++; if (rsp_valid_a !== 1'b1) begin errors++; $display("FAIL t6_pending: valid %b expected 1", rsp_valid_a); end
        aresetn = 1'b0;
        #1;
        checks++; if (rsp_valid_a !== 1'b0 || rsp_data_a !== 32'd0 || req_ready_a !== 1'b1) begin errors++; $display("FAIL t6_async_rsp: valid %b data %h ready %b expected 0 0 1", rsp_valid_a, rsp_data_a, req_ready_a); end
        checks++; if ({ovf_a, ovf_c} !== 10'd0) begin errors++; $display("FAIL t6_async_ovf: got %b expected 0", {ovf_a, ovf_c}); end
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL t6_no_ghost: valid %b expected 0", rsp_valid_a); end
        rsp_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_cycle_count();
        test_event_freeze();
        test_snapshot();
        test_wrap_clear();
        test_back_to_back();
        test_srst();
        test_err_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
